// File: rtl/reg_scoreboard_if.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_if
// Groups the decode-issue, writeback and status signals that connect the
// decode stage to the register scoreboard.
//
// Signals
//   issue_valid      decode presents an instruction this cycle
//   flush            cancel the presented instruction (no issue)
//   rs_addr/rs_used  first source register and its use flag
//   rt_addr/rt_used  second source register and its use flag
//   issue_writes     instruction writes a destination
//   issue_dest_addr  destination register
//   reg_wr           writeback write enable (shared with the register file)
//   reg_wr_addr      writeback destination
//   stall_flag       hold decode / register-file reads
//   issue_accept     instruction issued this cycle
//   inflight_count   registered total of pending writes
//   underflow_err    sticky writeback-without-pending-write error
//
// Modports
//   master  decode/writeback side (drives requests, observes status)
//   slave   scoreboard side
// ---------------------------------------------------------------------------
interface reg_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
);
    logic                     issue_valid;
    logic                     flush;
    logic [ADDR_W-1:0]        rs_addr;
    logic [ADDR_W-1:0]        rt_addr;
    logic                     rs_used;
    logic                     rt_used;
    logic                     issue_writes;
    logic [ADDR_W-1:0]        issue_dest_addr;
    logic                     reg_wr;
    logic [ADDR_W-1:0]        reg_wr_addr;
    logic                     stall_flag;
    logic                     issue_accept;
    logic [ADDR_W+CNT_W-1:0]  inflight_count;
    logic                     underflow_err;

    modport master (
        output issue_valid, flush, rs_addr, rt_addr, rs_used, rt_used,
               issue_writes, issue_dest_addr, reg_wr, reg_wr_addr,
        input  stall_flag, issue_accept, inflight_count, underflow_err
    );

    modport slave (
        input  issue_valid, flush, rs_addr, rt_addr, rs_used, rt_used,
               issue_writes, issue_dest_addr, reg_wr, reg_wr_addr,
        output stall_flag, issue_accept, inflight_count, underflow_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Counts outstanding register writes between decode issue and writeback and
// raises stall_flag while an instruction would read a register that still
// has a pending write, or would overflow a destination's pending counter.
//
// Ports
//   clk    clock, all state updates on posedge
//   reset  synchronous, active-high reset
//   sb     reg_scoreboard_if.slave (issue, writeback and status signals)
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    reg_scoreboard_if.slave  sb
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int IW    = ADDR_W + CNT_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [IW-1:0]    IFL_ONE = IW'(1);
    localparam logic [ADDR_W-1:0] ZERO_A = '0;

    // The array spans the full address space so any address indexes it
    // directly; entries 0 and >= NUM_REGS are held at zero.
    logic [CNT_W-1:0] pend [DEPTH];
    logic [IW-1:0]    inflight_q;
    logic             underflow_q;

    logic [CNT_W-1:0] pend_rs;
    logic [CNT_W-1:0] pend_rt;
    logic [CNT_W-1:0] pend_dst;
    logic [CNT_W-1:0] pend_wb;
    logic             wb_clear_rs;
    logic             wb_clear_rt;
    logic             raw_hazard;
    logic             struct_hazard;
    logic             stall;
    logic             accept;
    logic             inc_any;
    logic             dec_any;
    logic             wb_underflow;

    always_comb begin
        pend_rs  = pend[sb.rs_addr];
        pend_rt  = pend[sb.rt_addr];
        pend_dst = pend[sb.issue_dest_addr];
        pend_wb  = pend[sb.reg_wr_addr];

        // The register file writes on negedge and reads on posedge, so the
        // last pending write landing this cycle already resolves the hazard.
        wb_clear_rs = sb.reg_wr && (sb.reg_wr_addr == sb.rs_addr) && (pend_rs == CNT_ONE);
        wb_clear_rt = sb.reg_wr && (sb.reg_wr_addr == sb.rt_addr) && (pend_rt == CNT_ONE);

        raw_hazard = (sb.rs_used && (sb.rs_addr != ZERO_A) && (pend_rs != '0) && !wb_clear_rs)
                  || (sb.rt_used && (sb.rt_addr != ZERO_A) && (pend_rt != '0) && !wb_clear_rt);

        // A saturated destination may still issue when a writeback to the
        // same register frees a slot in the same cycle.
        struct_hazard = sb.issue_writes && (sb.issue_dest_addr != ZERO_A)
                     && (pend_dst == CNT_MAX)
                     && !(sb.reg_wr && (sb.reg_wr_addr == sb.issue_dest_addr));

        stall  = reset || (sb.issue_valid && (raw_hazard || struct_hazard));
        accept = sb.issue_valid && !stall && !sb.flush && !reset;

        inc_any      = accept && sb.issue_writes && (sb.issue_dest_addr != ZERO_A);
        dec_any      = sb.reg_wr && (sb.reg_wr_addr != ZERO_A) && (pend_wb != '0);
        wb_underflow = sb.reg_wr && (sb.reg_wr_addr != ZERO_A) && (pend_wb == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                pend[r] <= '0;
            end
            inflight_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (r == 0 || r >= NUM_REGS) begin
                    pend[r] <= '0;
                end else begin
                    case ({inc_any && (sb.issue_dest_addr == ADDR_W'(r)),
                           dec_any && (sb.reg_wr_addr == ADDR_W'(r))})
                        2'b10:   pend[r] <= pend[r] + CNT_ONE;
                        2'b01:   pend[r] <= pend[r] - CNT_ONE;
                        default: pend[r] <= pend[r];
                    endcase
                end
            end

            // Total moves by the same +1/-1 as the per-register counters;
            // an increment and decrement on different registers cancel.
            case ({inc_any, dec_any})
                2'b10:   inflight_q <= inflight_q + IFL_ONE;
                2'b01:   inflight_q <= inflight_q - IFL_ONE;
                default: inflight_q <= inflight_q;
            endcase

            if (wb_underflow) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign sb.stall_flag     = stall;
    assign sb.issue_accept   = accept;
    assign sb.inflight_count = inflight_q;
    assign sb.underflow_err  = underflow_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
// Directed-vector bench for reg_scoreboard. Each applied vector pushes its
// hand-computed expected outputs into a queue; a monitor on the falling
// edge pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;

    typedef struct {
        string           name;
        logic            stall;
        logic            accept;
        logic [6:0]      inflight;
        logic            underflow;
        logic            chk_state;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    bit   drive_done;

    reg_scoreboard_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) sb_if ();

    reg_scoreboard #(.NUM_REGS(32), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
        end
    endtask

    // Monitor: one expectation per driven vector, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "stall_flag", int'(sb_if.stall_flag), int'(e.stall));
            chk(e.name, "issue_accept", int'(sb_if.issue_accept), int'(e.accept));
            if (e.chk_state) begin
                chk(e.name, "inflight_count", int'(sb_if.inflight_count), int'(e.inflight));
                chk(e.name, "underflow_err", int'(sb_if.underflow_err), int'(e.underflow));
            end
        end
    end

    task automatic step(
        input string      nm,
        input logic       rst_i,
        input logic       iv,
        input logic       fl,
        input logic [4:0] rs,
        input logic       rsu,
        input logic [4:0] rt,
        input logic       rtu,
        input logic       iw,
        input logic [4:0] dst,
        input logic       wr,
        input logic [4:0] wa,
        input logic       e_stall,
        input logic       e_acc,
        input logic [6:0] e_inf,
        input logic       e_uf,
        input logic       chk_state
    );
        exp_t e;
        @(posedge clk);
        #1;
        e.name      = nm;
        e.stall     = e_stall;
        e.accept    = e_acc;
        e.inflight  = e_inf;
        e.underflow = e_uf;
        e.chk_state = chk_state;
        exp_q.push_back(e);
        reset                  = rst_i;
        sb_if.issue_valid      = iv;
        sb_if.flush            = fl;
        sb_if.rs_addr          = rs;
        sb_if.rs_used          = rsu;
        sb_if.rt_addr          = rt;
        sb_if.rt_used          = rtu;
        sb_if.issue_writes     = iw;
        sb_if.issue_dest_addr  = dst;
        sb_if.reg_wr           = wr;
        sb_if.reg_wr_addr      = wa;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        drive_done = 1'b0;
        reset                 = 1'b1;
        sb_if.issue_valid     = 1'b0;
        sb_if.flush           = 1'b0;
        sb_if.rs_addr         = '0;
        sb_if.rs_used         = 1'b0;
        sb_if.rt_addr         = '0;
        sb_if.rt_used         = 1'b0;
        sb_if.issue_writes    = 1'b0;
        sb_if.issue_dest_addr = '0;
        sb_if.reg_wr          = 1'b0;
        sb_if.reg_wr_addr     = '0;

        //    name        rst iv fl rs   rsu rt  rtu iw dst  wr wa   stl acc inf uf chk
        // Reset then idle
        step("rst_a",     1, 1, 0, 0, 0, 0, 0, 1, 3,  0, 0,   1, 0, 0, 0, 0);
        step("rst_b",     1, 1, 0, 0, 0, 0, 0, 1, 3,  0, 0,   1, 0, 0, 0, 1);
        step("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 1);
        // RAW stall on rs
        step("raw_iss5",  0, 1, 0, 0, 0, 0, 0, 1, 5,  0, 0,   0, 1, 0, 0, 1);
        step("raw_st1",   0, 1, 0, 5, 1, 0, 0, 0, 0,  0, 0,   1, 0, 1, 0, 1);
        step("raw_st2",   0, 1, 0, 5, 1, 0, 0, 0, 0,  0, 0,   1, 0, 1, 0, 1);
        step("raw_wbclr", 0, 1, 0, 5, 1, 0, 0, 0, 0,  1, 5,   0, 1, 1, 0, 1);
        step("raw_after", 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 1);
        // RAW stall on rt, and unused rt never stalls
        step("rt_iss6",   0, 1, 0, 0, 0, 0, 0, 1, 6,  0, 0,   0, 1, 0, 0, 1);
        step("rt_stall",  0, 1, 0, 0, 0, 6, 1, 0, 0,  0, 0,   1, 0, 1, 0, 1);
        step("rt_unused", 0, 1, 0, 0, 0, 6, 0, 0, 0,  0, 0,   0, 1, 1, 0, 1);
        step("rt_wb6",    0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 6,   0, 0, 1, 0, 1);
        // Simultaneous issue and writeback to the same register
        step("sim_iss7",  0, 1, 0, 0, 0, 0, 0, 1, 7,  0, 0,   0, 1, 0, 0, 1);
        step("sim_both",  0, 1, 0, 0, 0, 0, 0, 1, 7,  1, 7,   0, 1, 1, 0, 1);
        step("sim_raw",   0, 1, 0, 7, 1, 0, 0, 0, 0,  0, 0,   1, 0, 1, 0, 1);
        step("sim_wb7",   0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 7,   0, 0, 1, 0, 1);
        // Structural limit on register 4
        step("str_i1",    0, 1, 0, 0, 0, 0, 0, 1, 4,  0, 0,   0, 1, 0, 0, 1);
        step("str_i2",    0, 1, 0, 0, 0, 0, 0, 1, 4,  0, 0,   0, 1, 1, 0, 1);
        step("str_i3",    0, 1, 0, 0, 0, 0, 0, 1, 4,  0, 0,   0, 1, 2, 0, 1);
        step("str_full",  0, 1, 0, 0, 0, 0, 0, 1, 4,  0, 0,   1, 0, 3, 0, 1);
        step("str_wbiss", 0, 1, 0, 0, 0, 0, 0, 1, 4,  1, 4,   0, 1, 3, 0, 1);
        step("str_rdwb3", 0, 1, 0, 4, 1, 0, 0, 0, 0,  1, 4,   1, 0, 3, 0, 1);
        step("str_wb2",   0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4,   0, 0, 2, 0, 1);
        step("str_rdwb1", 0, 1, 0, 4, 1, 0, 0, 0, 0,  1, 4,   0, 1, 1, 0, 1);
        // Register zero
        step("z_iss0",    0, 1, 0, 0, 0, 0, 0, 1, 0,  0, 0,   0, 1, 0, 0, 1);
        step("z_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 1);
        step("z_read0",   0, 1, 0, 0, 1, 0, 1, 0, 0,  0, 0,   0, 1, 0, 0, 1);
        step("z_wb0",     0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,   0, 0, 0, 0, 1);
        step("z_after",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 1);
        // Flush
        step("fl_iss9",   0, 1, 1, 0, 0, 0, 0, 1, 9,  0, 0,   0, 0, 0, 0, 1);
        step("fl_read9",  0, 1, 0, 9, 1, 0, 0, 0, 0,  0, 0,   0, 1, 0, 0, 1);
        step("fl_iss10",  0, 1, 0, 0, 0, 0, 0, 1, 10, 0, 0,   0, 1, 0, 0, 1);
        step("fl_stall",  0, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 1);
        step("fl_wb10",   0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 10,  0, 0, 1, 0, 1);
        // Underflow
        step("uf_wb12",   0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 12,  0, 0, 0, 0, 1);
        step("uf_set",    0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 1, 1);
        step("uf_read12", 0, 1, 0, 12, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 1);
        step("uf_hold",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 1, 1);
        // Reset mid-operation discards pending writes
        step("mr_iss15",  0, 1, 0, 0, 0, 0, 0, 1, 15, 0, 0,   0, 1, 0, 1, 1);
        step("mr_reset",  1, 1, 0, 15, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 1);
        step("mr_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 1);
        step("mr_read15", 0, 1, 0, 15, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1);
        step("mr_wb15",   0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 15,  0, 0, 0, 0, 1);
        step("mr_uf",     0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 1, 1);

        drive_done = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
